quad_encoder_gen: RTL and testbench
===================================

QUAD_ENCODER_GEN -- requirements
Module: quad_encoder_gen

Interface
REQ-001 SHALL have parameter CPR, default 1000, quadrature states per revolution (POS wraps at CPR).
REQ-002 SHALL have parameter DIV_W, default 16, width of STEP_DIV.
REQ-003 SHALL have port CLK  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port PM  input  1  continuous-run enable (1 = free-run).
REQ-006 SHALL have port MOTORDIRECTION  input  1  1 = forward (A leads B, POS increments), 0 = reverse.
REQ-007 SHALL have port STEP_DIV  input  DIV_W  CLK cycles per quadrature step; 0 = no stepping.
REQ-008 SHALL have port START  input  1  one-cycle pulse requesting a counted move.
REQ-009 SHALL have port STEPS  input  12  step count for a counted move, sampled on START.
REQ-010 SHALL have port OPTOA  output  1  quadrature channel A, registered.
REQ-011 SHALL have port OPTOB  output  1  quadrature channel B, registered.
REQ-012 SHALL have port INDEX  output  1  once-per-rev pulse, registered.
REQ-013 SHALL have port POS  output  12  emulated position, 0..CPR-1.
REQ-014 SHALL have port BUSY  output  1  high while a counted move runs.
REQ-015 SHALL have port DONE  output  1  one-cycle pulse at counted-move completion.

Function
REQ-016 SHALL implement states IDLE, RUN, MOVE.
REQ-017 IDLE->RUN when PM=1; RUN->IDLE when PM=0; IDLE->MOVE on START=1 with PM=0 and STEPS!=0.
REQ-018 START with STEPS=0 in IDLE SHALL produce DONE next cycle, no steps, no BUSY.
REQ-019 START while BUSY or PM=1 SHALL be ignored.
REQ-020 PM=1 during MOVE SHALL abort the move (no DONE), BUSY low, enter RUN.
REQ-021 Prescaler SHALL clear on entry to RUN/MOVE and in IDLE; a step SHALL occur on the cycle the prescaler reaches STEP_DIV-1, then prescaler reloads to 0 (first step STEP_DIV cycles after entry).
REQ-022 STEP_DIV SHALL be latched at each prescaler reload; changes mid-period take effect next period.
REQ-023 Latched STEP_DIV=0 SHALL suppress steps while remaining in RUN/MOVE.
REQ-024 Forward step sequence (A,B): 00->10->11->01->00; reverse is the exact inverse.
REQ-025 Exactly one of OPTOA/OPTOB SHALL change per step; never both.
REQ-026 MOTORDIRECTION SHALL be sampled at each step; reversal SHALL not skip or repeat a state.
REQ-027 POS SHALL increment forward, wrapping CPR-1->0; decrement reverse, wrapping 0->CPR-1.
REQ-028 INDEX SHALL be 1 exactly while POS=0 following a step into 0, cleared on the next step.
REQ-029 MOVE SHALL take exactly STEPS steps; DONE SHALL pulse and BUSY fall the cycle after the final step; then IDLE.
REQ-030 Outputs SHALL hold their values in IDLE (POS, OPTOA, OPTOB retained).

Reset
REQ-031 RESET_N=0 SHALL asynchronously force IDLE, OPTOA=0, OPTOB=0, INDEX=0, POS=0, BUSY=0, DONE=0, prescaler=0, step counter=0.
REQ-032 Reset mid-move SHALL abandon the move with no DONE; release SHALL take effect on the next CLK edge.

Configuration
REQ-033 Macro QUAD_INDEX_EN defined: INDEX behaves per REQ-028.
REQ-034 Macro QUAD_INDEX_EN undefined: INDEX tied to 0, index logic omitted; all other behaviour unchanged.

Verification
REQ-035 Reset, PM=1, DIR=1, STEP_DIV=4 -> first step 4 cycles later, (A,B) 10,11,01,00 every 4 cycles, POS 1,2,3,4.
REQ-036 PM=1, DIR=0 from POS=0, STEP_DIV=1 -> POS=999 after first step, INDEX=0; 1000 steps -> POS=0, INDEX=1 (with QUAD_INDEX_EN).
REQ-037 PM=0, START with STEPS=250, STEP_DIV=2 -> BUSY for 500 cycles, POS=250, single DONE pulse, IDLE.
REQ-038 DIR toggled 1->0 after 3 forward steps -> states 10,11,01 then 11; POS 3 then 2; never both channels change.
REQ-039 RESET_N low mid-MOVE at POS=100 -> all outputs 0, no DONE; PM=1 during MOVE -> BUSY falls, no DONE, stepping continues.
REQ-040 START with STEPS=0 -> DONE pulse next cycle, POS unchanged, BUSY stays 0.

Source files
------------

// File: rtl/quad_encoder_gen.sv
`default_nettype none
// ============================================================================
// Module   : quad_encoder_gen
// Purpose  : Quadrature encoder emulator. Generates A/B/INDEX channels and a
//            wrapping position count, either free-running (PM=1) or for a
//            counted move of STEPS steps started by a START pulse.
//            Optional macro QUAD_INDEX_EN enables the once-per-rev INDEX
//            pulse; without it INDEX is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module quad_encoder_gen #(
    parameter int CPR   = 1000,
    parameter int DIV_W = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             PM,
    input  logic             MOTORDIRECTION,
    input  logic [DIV_W-1:0] STEP_DIV,
    input  logic             START,
    input  logic [11:0]      STEPS,
    output logic             OPTOA,
    output logic             OPTOB,
    output logic             INDEX,
    output logic [11:0]      POS,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [1:0]       S_IDLE    = 2'd0;
    localparam logic [1:0]       S_RUN     = 2'd1;
    localparam logic [1:0]       S_MOVE    = 2'd2;
    localparam logic [11:0]      C_POS_MAX = 12'(CPR - 1);
    localparam logic [DIV_W-1:0] C_DIV_ONE = DIV_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [DIV_W-1:0] r_presc;
    logic [DIV_W-1:0] r_div;
    logic [11:0]      r_cnt;
    logic [11:0]      r_pos;
    logic             r_a;
    logic             r_b;
    logic             r_done;
    logic             w_active;
    logic             w_step;
    logic             w_last;
    logic             w_reload;
    logic             w_done_set;
    logic [1:0]       w_phase;
    logic [1:0]       w_phase_nxt;
    logic [11:0]      w_pos_nxt;

    // A step fires on the cycle the prescaler reaches the latched divider - 1
    assign w_active = (r_state == S_RUN) || (r_state == S_MOVE);
    assign w_step   = w_active && (r_div != '0) && (r_presc == r_div - C_DIV_ONE);
    assign w_last   = (r_state == S_MOVE) && w_step && (r_cnt == 12'd1);
    // Prescaler restarts whenever the state changes and is held clear in IDLE
    assign w_reload = (w_state_nxt != r_state) || (r_state == S_IDLE);

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; PM has priority over move completion
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (PM) begin
                    w_state_nxt = S_RUN;
                end else if (START && (STEPS != 12'd0)) begin
                    w_state_nxt = S_MOVE;
                end
            end
            S_RUN: begin
                if (!PM) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MOVE: begin
                if (PM) begin
                    w_state_nxt = S_RUN;
                end else if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: BUSY follows MOVE, DONE on zero-length or final step
    always_comb begin
        BUSY       = (r_state == S_MOVE);
        w_done_set = ((r_state == S_IDLE) && !PM && START && (STEPS == 12'd0))
                   || (w_last && !PM);
    end

    // Prescaler with divider re-latched at every reload; a zero divider is
    // re-sampled every cycle so a new non-zero value restarts stepping
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_presc <= '0;
            r_div   <= '0;
        end else if (w_reload || w_step || (r_div == '0)) begin
            r_presc <= '0;
            r_div   <= STEP_DIV;
        end else begin
            r_presc <= r_presc + C_DIV_ONE;
        end
    end

    // Quadrature phase as a 2-bit counter: phase = {B, A^B}
    always_comb begin
        w_phase     = {r_b, r_a ^ r_b};
        w_phase_nxt = MOTORDIRECTION ? (w_phase + 2'd1) : (w_phase - 2'd1);
        if (MOTORDIRECTION) begin
            w_pos_nxt = (r_pos == C_POS_MAX) ? 12'd0 : (r_pos + 12'd1);
        end else begin
            w_pos_nxt = (r_pos == 12'd0) ? C_POS_MAX : (r_pos - 12'd1);
        end
    end

    // Channel and position registers advance only on a step
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_a   <= 1'b0;
            r_b   <= 1'b0;
            r_pos <= 12'd0;
        end else if (w_step) begin
            r_a   <= w_phase_nxt[1] ^ w_phase_nxt[0];
            r_b   <= w_phase_nxt[1];
            r_pos <= w_pos_nxt;
        end
    end

    // Remaining-step counter loaded on an accepted START
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= 12'd0;
        end else if ((r_state == S_IDLE) && !PM && START) begin
            r_cnt <= STEPS;
        end else if ((r_state == S_MOVE) && w_step) begin
            r_cnt <= r_cnt - 12'd1;
        end
    end

    // DONE is a registered single-cycle pulse
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_set;
        end
    end

`ifdef QUAD_INDEX_EN
    logic r_index;

    // INDEX set by a step landing on 0, cleared by the next step
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_index <= 1'b0;
        end else if (w_step) begin
            r_index <= (w_pos_nxt == 12'd0);
        end
    end

    assign INDEX = r_index;
`else
    assign INDEX = 1'b0;
`endif

    assign OPTOA = r_a;
    assign OPTOB = r_b;
    assign POS   = r_pos;
    assign DONE  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_encoder_gen
// Purpose  : Directed self-checking bench for quad_encoder_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_encoder_gen;

    logic        clk;
    logic        rst_n;
    logic        pm;
    logic        dir;
    logic [15:0] step_div;
    logic        start;
    logic [11:0] steps;
    logic        opto_a;
    logic        opto_b;
    logic        index;
    logic [11:0] pos;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

`ifdef QUAD_INDEX_EN
    localparam logic c_idx = 1'b1;
`else
    localparam logic c_idx = 1'b0;
`endif

    // Forward (A,B) sequence from 00
    logic [1:0] c_fwd [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    quad_encoder_gen #(.CPR(1000), .DIV_W(16)) dut (
        .CLK            (clk),
        .RESET_N        (rst_n),
        .PM             (pm),
        .MOTORDIRECTION (dir),
        .STEP_DIV       (step_div),
        .START          (start),
        .STEPS          (steps),
        .OPTOA          (opto_a),
        .OPTOB          (opto_b),
        .INDEX          (index),
        .POS            (pos),
        .BUSY           (busy),
        .DONE           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        pm       = 1'b0;
        dir      = 1'b1;
        step_div = 16'd0;
        start    = 1'b0;
        steps    = 12'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] ab_prev;
        int busy_cnt;
        int done_cnt;
        int done_pos;
        int done_busy;

        // ---------------- reset state
        do_reset();
        check("rst_a",     opto_a, 0);
        check("rst_b",     opto_b, 0);
        check("rst_index", index,  0);
        check("rst_pos",   pos,    0);
        check("rst_busy",  busy,   0);
        check("rst_done",  done,   0);

        // ---------------- free run forward, STEP_DIV=4
        pm = 1'b1; dir = 1'b1; step_div = 16'd4;
        @(negedge clk);   // after entry edge
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("run4_ab",  {opto_a, opto_b}, c_fwd[(k / 4) % 4]);
            check("run4_pos", pos, k / 4);
        end
        pm = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_hold_pos", pos, 4);
        check("idle_hold_ab",  {opto_a, opto_b}, 2'b00);

        // ---------------- zero divider suppresses steps in RUN
        do_reset();
        pm = 1'b1; step_div = 16'd0;
        repeat (10) @(negedge clk);
        check("div0_pos", pos, 0);
        check("div0_ab",  {opto_a, opto_b}, 2'b00);
        pm = 1'b0;
        @(negedge clk);

        // ---------------- direction reversal after 3 forward steps
        do_reset();
        pm = 1'b1; dir = 1'b1; step_div = 16'd1;
        @(negedge clk);
        ab_prev = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("rev_fwd_ab",  {opto_a, opto_b}, c_fwd[k]);
            check("rev_fwd_pos", pos, k);
            check("rev_one_edge", $countones({opto_a, opto_b} ^ ab_prev), 1);
            ab_prev = {opto_a, opto_b};
        end
        dir = 1'b0; pm = 1'b0;
        @(negedge clk);
        check("rev_ab",  {opto_a, opto_b}, 2'b11);
        check("rev_pos", pos, 2);
        check("rev_one_edge", $countones({opto_a, opto_b} ^ ab_prev), 1);
        @(negedge clk);
        check("rev_idle_pos", pos, 2);

        // ---------------- reverse wrap and full revolution
        do_reset();
        pm = 1'b1; dir = 1'b0; step_div = 16'd1;
        @(negedge clk);
        @(negedge clk);
        check("wrap_rev_pos",   pos,   999);
        check("wrap_rev_index", index, 0);
        repeat (999) @(negedge clk);
        check("rev_full_pos",   pos,   0);
        check("rev_full_index", index, c_idx);
        @(negedge clk);
        check("idx_clr_pos",   pos,   999);
        check("idx_clr_index", index, 0);
        dir = 1'b1; pm = 1'b0;
        @(negedge clk);
        check("wrap_fwd_pos",   pos,   0);
        check("wrap_fwd_index", index, c_idx);
        @(negedge clk);
        check("idle_index_hold", index, c_idx);

        // ---------------- counted move 250 steps, STEP_DIV=2, START ignored while busy
        do_reset();
        step_div = 16'd2; dir = 1'b1; steps = 12'd250; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_pos = -1; done_busy = -1;
        for (int i = 0; i < 510; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_pos  = pos;
                done_busy = busy;
            end
            if (i == 100) begin start = 1'b1; steps = 12'd5; end
            if (i == 101) start = 1'b0;
            @(negedge clk);
        end
        check("move_busy_cycles", busy_cnt,  500);
        check("move_done_count",  done_cnt,  1);
        check("move_done_pos",    done_pos,  250);
        check("move_done_busy",   done_busy, 0);
        check("move_final_pos",   pos,       250);

        // ---------------- zero-length move
        steps = 12'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_pos",  pos,  250);
        @(negedge clk);
        check("zero_done_clr", done, 0);
        check("zero_pos_hold", pos,  250);

        // ---------------- reset mid-move at POS=100
        do_reset();
        step_div = 16'd1; steps = 12'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("rm_pos_before", pos,  100);
        check("rm_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rm_pos",  pos,               0);
        check("rm_ab",   {opto_a, opto_b},  0);
        check("rm_busy", busy,              0);
        check("rm_done", done,              0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("rm_no_done",  done_cnt, 0);
        check("rm_pos_idle", pos,      0);

        // ---------------- PM abort mid-move
        step_div = 16'd1; steps = 12'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        check("ab_pos_before", pos, 50);
        pm = 1'b1;
        @(negedge clk);
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        check("ab_pos",  pos,  51);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("ab_no_done", done_cnt, 0);
        check("ab_run_pos", pos, 61);
        pm = 1'b0;
        repeat (2) @(negedge clk);
        check("ab_stop_pos", pos, 62);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL timeout: observed 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
